pipelined_adder: RTL and testbench



---
 rtl/arith_pkg.sv | 17 +
 rtl/adder_slice.sv | 20 ++
 rtl/pipelined_adder.sv | 106 ++++++++++
 tb/tb_pipelined_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library constants and elaboration helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int sliceWidth(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit adderCfgOk(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational N-bit ripple add of one operand slice with carry in/out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
module adder_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carryIn,
    output logic [N-1:0] sum,
    output logic         carryOut,
    output logic         msbCarryIn
);

    assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carryIn};

    // Carry into the top bit falls out of that bit's sum; for N=1 it is carryIn.
    assign msbCarryIn = a[N-1] ^ b[N-1] ^ sum[N-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES registered carry-chain slices.
// Latency: STAGES cycles from accept to OutValid; 1 beat/cycle when not stalled.
// Backpressure: OutValid & ~OutReady freezes every stage; InReady drops in the same cycle.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             CarryIn,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] SumOut,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int SW = sliceWidth(WIDTH, STAGES);

    if (!adderCfgOk(WIDTH, STAGES)) begin : gBadCfg
        $error("pipelined_adder: WIDTH=%0d STAGES=%0d is not a legal slice split", WIDTH, STAGES);
    end

    // aReg[k] carries finished sum slices 0..k below the still-pending A slices.
    logic [WIDTH-1:0] aReg  [STAGES];
    logic [WIDTH-1:0] bReg  [STAGES];
    logic             cReg  [STAGES];
    logic             vReg  [STAGES];
    logic             ovReg [STAGES];

    logic [WIDTH-1:0] bEff;
    logic             cinEff;
    logic             stall;

    assign bEff    = (Sub == OP_ADD) ? InputB : ~InputB;
    assign cinEff  = CarryIn ^ (Sub == OP_SUB);
    assign stall   = vReg[STAGES-1] & ~OutReady;
    assign InReady = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic [WIDTH-1:0] aIn;
        logic [WIDTH-1:0] bIn;
        logic             cIn;
        logic             vIn;
        logic [SW-1:0]    sliceSum;
        logic             sliceCout;
        logic             sliceMsbCin;
        logic [WIDTH-1:0] aNext;

        if (k == 0) begin : gHead
            assign aIn = InputA;
            assign bIn = bEff;
            assign cIn = cinEff;
            assign vIn = InValid;
        end else begin : gBody
            assign aIn = aReg[k-1];
            assign bIn = bReg[k-1];
            assign cIn = cReg[k-1];
            assign vIn = vReg[k-1];
        end

        adder_slice #(.N(SW)) uSlice (
            .a          (aIn[k*SW +: SW]),
            .b          (bIn[k*SW +: SW]),
            .carryIn    (cIn),
            .sum        (sliceSum),
            .carryOut   (sliceCout),
            .msbCarryIn (sliceMsbCin)
        );

        always_comb begin
            aNext             = aIn;
            aNext[k*SW +: SW] = sliceSum;
        end

        always_ff @(posedge Clk) begin
            if (!ResetN) begin
                vReg[k]  <= 1'b0;
                aReg[k]  <= '0;
                bReg[k]  <= '0;
                cReg[k]  <= 1'b0;
                ovReg[k] <= 1'b0;
            end else if (!stall) begin
                vReg[k]  <= vIn;
                aReg[k]  <= aNext;
                bReg[k]  <= bIn;
                cReg[k]  <= sliceCout;
                // Only the last stage's value is the word overflow; earlier ones are slice-local.
                ovReg[k] <= sliceMsbCin ^ sliceCout;
            end
        end
    end

    assign OutValid = vReg[STAGES-1];
    assign SumOut   = aReg[STAGES-1];
    assign CarryOut = cReg[STAGES-1];
    assign Overflow = ovReg[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four WIDTH=8 instances (STAGES 2,1,4,8) checked
// against an arithmetic reference model with directed and random traffic.
module tb_pipelined_adder;

    localparam int NI        = 4;
    localparam int STG [NI]  = '{2, 1, 4, 8};
    localparam int BEATS     = 10000;

    logic       clk = 1'b0;
    logic       resetN;
    logic       inV   [NI];
    logic       inRdy [NI];
    logic [7:0] inA   [NI];
    logic [7:0] inB   [NI];
    logic       cIn   [NI];
    logic       sub   [NI];
    logic       outV  [NI];
    logic       outR  [NI];
    logic [7:0] sumO  [NI];
    logic       coO   [NI];
    logic       ovO   [NI];

    logic [9:0] q [NI][$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gDut
        pipelined_adder #(.WIDTH(8), .STAGES(STG[g])) uDut (
            .Clk      (clk),
            .ResetN   (resetN),
            .InValid  (inV[g]),
            .InReady  (inRdy[g]),
            .InputA   (inA[g]),
            .InputB   (inB[g]),
            .CarryIn  (cIn[g]),
            .Sub      (sub[g]),
            .OutValid (outV[g]),
            .OutReady (outR[g]),
            .SumOut   (sumO[g]),
            .CarryOut (coO[g]),
            .Overflow (ovO[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [9:0] packRes(input logic ov, input logic co, input logic [7:0] s);
        return {ov, co, s};
    endfunction

    // Reference: unsigned sum gives SumOut/CarryOut, signed sum gives Overflow.
    function automatic logic [9:0] refModel(input logic [7:0] a, input logic [7:0] b,
                                            input logic ci, input logic sb);
        int ub, c, full, sa, sbv, ss;
        ub   = sb ? (255 - int'(b)) : int'(b);
        c    = (ci != sb) ? 1 : 0;
        full = int'(a) + ub + c;
        sa   = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sbv  = (ub >= 128) ? ub - 256 : ub;
        ss   = sa + sbv + c;
        return packRes((ss > 127) || (ss < -128), full > 255, 8'(full));
    endfunction

    task automatic observe(input int i);
        logic [9:0] want;
        if (outV[i] && outR[i]) begin
            check($sformatf("orphan_out%0d", i), 32'(q[i].size() > 0), 1);
            if (q[i].size() > 0) begin
                want = q[i].pop_front();
                check($sformatf("result%0d", i), 32'(packRes(ovO[i], coO[i], sumO[i])), 32'(want));
            end
        end
        if (inV[i] && inRdy[i])
            q[i].push_back(refModel(inA[i], inB[i], cIn[i], sub[i]));
    endtask

    task automatic runSingle(input int i, input logic [7:0] a, input logic [7:0] b,
                             input logic ci, input logic sb, input logic [9:0] want,
                             input string tag);
        int lat;
        @(negedge clk);
        inA[i] = a; inB[i] = b; cIn[i] = ci; sub[i] = sb;
        inV[i] = 1'b1; outR[i] = 1'b1;
        #1 check({tag, "_inrdy"}, 32'(inRdy[i]), 1);
        @(negedge clk);
        inV[i] = 1'b0;
        lat = 1;
        while (outV[i] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        #1;
        check({tag, "_lat"}, 32'(lat), 32'(STG[i]));
        check({tag, "_res"}, 32'(packRes(ovO[i], coO[i], sumO[i])), 32'(want));
    endtask

    initial begin
        resetN = 1'b0;
        for (int i = 0; i < NI; i++) begin
            inV[i] = 1'b0; outR[i] = 1'b1; inA[i] = '0; inB[i] = '0; cIn[i] = 1'b0; sub[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_vld%0d", i), 32'(outV[i]), 0);
            check($sformatf("rst_res%0d", i), 32'(packRes(ovO[i], coO[i], sumO[i])), 0);
            check($sformatf("rst_rdy%0d", i), 32'(inRdy[i]), 1);
        end

        runSingle(0, 8'hFF, 8'h01, 1'b0, 1'b0, packRes(1'b0, 1'b1, 8'h00), "wrap");
        runSingle(0, 8'h7F, 8'h01, 1'b0, 1'b0, packRes(1'b1, 1'b0, 8'h80), "ovf");
        runSingle(0, 8'h05, 8'h07, 1'b0, 1'b1, packRes(1'b0, 1'b0, 8'hFE), "sub");

        begin : streamTest
            int sent;
            sent = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                outR[0] = !(c >= 3 && c <= 5);
                inV[0]  = (sent < 6);
                inA[0]  = 8'(sent); inB[0] = 8'h10; cIn[0] = 1'b0; sub[0] = 1'b0;
                #1;
                check($sformatf("strm_rdy_c%0d", c), 32'(inRdy[0]), (c >= 3 && c <= 5) ? 0 : 1);
                if (c >= 3 && c <= 5) begin
                    check($sformatf("stall_vld_c%0d", c), 32'(outV[0]), 1);
                    check($sformatf("stall_hold_c%0d", c),
                          32'(packRes(ovO[0], coO[0], sumO[0])), 32'(packRes(1'b0, 1'b0, 8'h11)));
                end
                if (inV[0] && inRdy[0]) sent++;
                observe(0);
            end
            check("strm_sent", 32'(sent), 6);
            check("strm_drain", 32'(q[0].size()), 0);
        end

        @(negedge clk);
        outR[0] = 1'b1; inV[0] = 1'b1; inA[0] = 8'h11; inB[0] = 8'h22;
        #1 observe(0);
        @(negedge clk);
        inA[0] = 8'h33;
        #1 observe(0);
        @(negedge clk);
        inV[0] = 1'b0;
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        q[0].delete();
        #1;
        check("midrst_vld", 32'(outV[0]), 0);
        check("midrst_sum", 32'(sumO[0]), 0);
        check("midrst_flags", 32'({coO[0], ovO[0]}), 0);
        check("midrst_rdy", 32'(inRdy[0]), 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 check($sformatf("midrst_stale_c%0d", c), 32'(outV[0]), 0);
        end

        for (int i = 0; i < NI; i++)
            runSingle(i, 8'hAA, 8'h55, 1'b1, 1'b0, packRes(1'b0, 1'b1, 8'h00),
                      $sformatf("sweep_s%0d", STG[i]));

        begin : randomTest
            int sentR [NI];
            int cyc;
            bit busy;
            for (int i = 0; i < NI; i++) sentR[i] = 0;
            cyc  = 0;
            busy = 1'b1;
            while (busy && cyc < 60000) begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    outR[i] = ($urandom_range(0, 3) != 0);
                    inV[i]  = (sentR[i] < BEATS) && ($urandom_range(0, 4) != 0);
                    inA[i]  = 8'($urandom);
                    inB[i]  = 8'($urandom);
                    cIn[i]  = 1'($urandom);
                    sub[i]  = 1'($urandom);
                end
                #1;
                busy = 1'b0;
                for (int i = 0; i < NI; i++) begin
                    if (inV[i] && inRdy[i]) sentR[i]++;
                    observe(i);
                    if (sentR[i] < BEATS || q[i].size() != 0) busy = 1'b1;
                end
                cyc++;
            end
            for (int i = 0; i < NI; i++) begin
                check($sformatf("rand_sent_s%0d", STG[i]), 32'(sentR[i]), 32'(BEATS));
                check($sformatf("rand_drain_s%0d", STG[i]), 32'(q[i].size()), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
